// File: rtl/layer_cfg_seq.sv
// -----------------------------------------------------------------------------
// layer_cfg_seq
//   Walks a small table of per-layer configuration entries and hands each
//   valid entry to a downstream guard-gen controller with a valid/ready
//   handshake, then waits for that controller to report completion.
//
//   Optional feature macro: LAYER_SEQ_LOOP_EN
//     When it is defined, an extra input loop_i lets the sequence wrap back to
//     layer 0 instead of finishing. When it is not defined, the port is absent
//     and a run always ends after the requested number of layers.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   cfg_we/addr/wdata table write port (honoured only while idle)
//                     wdata = {w[37:30], h[29:22], c[21:14], co[13:6],
//                              shift_bias[5:2], kernel_mode[1], is_diff[0]}
//   layer_cnt_i      number of layers to run, captured with start
//   start            single-cycle run request
//   loop_i           (LAYER_SEQ_LOOP_EN only) wrap to layer 0 at end of pass
//   busy, done       run in progress / one-cycle end-of-run pulse
//   skip_err         one-cycle pulse when a layer with a zero dimension is skipped
//   cur_layer        index of the layer in flight
//   ctrl_valid/ready handshake to the downstream controller
//   ctrl_finish      downstream controller finished the current layer
//   *_o              registered fields of the current layer, is_first_o marks
//                    the first layer of a run
// -----------------------------------------------------------------------------
module layer_cfg_seq #(
  parameter int LAYER_NUM = 8,
  parameter int AW        = $clog2(LAYER_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [37:0]   cfg_wdata,
  input  logic [AW:0]   layer_cnt_i,
  input  logic          start,
`ifdef LAYER_SEQ_LOOP_EN
  input  logic          loop_i,
`endif
  output logic          busy,
  output logic          done,
  output logic          skip_err,
  output logic [AW-1:0] cur_layer,
  output logic          ctrl_valid,
  input  logic          ctrl_ready,
  input  logic          ctrl_finish,
  output logic [7:0]    w_num_o,
  output logic [7:0]    h_num_o,
  output logic [7:0]    c_num_o,
  output logic [7:0]    co_num_o,
  output logic [3:0]    shift_bias_o,
  output logic          kernel_mode_o,
  output logic          is_diff_o,
  output logic          is_first_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [37:0] tbl [LAYER_NUM];
  logic [AW:0] cnt;

  logic [37:0] ent;
  logic        ent_zero;
  logic [AW:0] nxt_idx;
  logic        more;
  logic        adv;
  logic        loop_req;
  logic        cnt_bad;

  assign ent      = tbl[cur_layer];
  assign ent_zero = (ent[37:30] == 8'd0) || (ent[29:22] == 8'd0) ||
                    (ent[21:14] == 8'd0) || (ent[13:6]  == 8'd0);
  assign nxt_idx  = {1'b0, cur_layer} + {{AW{1'b0}}, 1'b1};
  assign more     = (nxt_idx < cnt);
  assign cnt_bad  = (layer_cnt_i == '0) || (layer_cnt_i > (AW+1)'(LAYER_NUM));

  // A layer ends either by being skipped at fetch or by the downstream finish.
  assign adv = ((state == S_FETCH) && ent_zero) ||
               ((state == S_RUN) && ctrl_finish);

`ifdef LAYER_SEQ_LOOP_EN
  assign loop_req = loop_i;
`else
  assign loop_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      skip_err      <= 1'b0;
      cur_layer     <= '0;
      ctrl_valid    <= 1'b0;
      w_num_o       <= '0;
      h_num_o       <= '0;
      c_num_o       <= '0;
      co_num_o      <= '0;
      shift_bias_o  <= '0;
      kernel_mode_o <= 1'b0;
      is_diff_o     <= 1'b0;
      is_first_o    <= 1'b0;
      for (int i = 0; i < LAYER_NUM; i++) tbl[i] <= '0;
    end else begin
      done     <= 1'b0;
      skip_err <= 1'b0;

      // Table writes only while idle; a write coinciding with start lands
      // before the first fetch, so the run sees the new entry.
      if ((state == S_IDLE) && cfg_we) tbl[cfg_addr] <= cfg_wdata;

      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            cur_layer  <= '0;
            is_first_o <= 1'b1;
            cnt        <= layer_cnt_i;
            if (cnt_bad) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          w_num_o       <= ent[37:30];
          h_num_o       <= ent[29:22];
          c_num_o       <= ent[21:14];
          co_num_o      <= ent[13:6];
          shift_bias_o  <= ent[5:2];
          kernel_mode_o <= ent[1];
          is_diff_o     <= ent[0];
          if (ent_zero) begin
            skip_err <= 1'b1;
          end else begin
            state      <= S_ISSUE;
            ctrl_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ctrl_ready) begin
            state      <= S_RUN;
            ctrl_valid <= 1'b0;
          end
        end
        S_RUN: begin
          // completion handled by the shared advance logic below
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (adv) begin
        if (more) begin
          state      <= S_FETCH;
          cur_layer  <= nxt_idx[AW-1:0];
          is_first_o <= 1'b0;
        end else if (loop_req) begin
          state      <= S_FETCH;
          cur_layer  <= '0;
          is_first_o <= 1'b0;
        end else begin
          state <= S_DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_cfg_seq.sv
// Directed bench for layer_cfg_seq (default LAYER_NUM=8).
module tb_layer_cfg_seq;

  localparam int AW = 3;

  localparam logic [37:0] E0  = {8'd4,  8'd5,  8'd6,  8'd7,  4'd3,  1'b1, 1'b0};
  localparam logic [37:0] E1  = {8'd10, 8'd11, 8'd12, 8'd13, 4'd9,  1'b0, 1'b1};
  localparam logic [37:0] E1Z = {8'd10, 8'd11, 8'd0,  8'd13, 4'd9,  1'b0, 1'b1};
  localparam logic [37:0] E2  = {8'd1,  8'd2,  8'd3,  8'd4,  4'd15, 1'b1, 1'b1};
  localparam logic [37:0] JUNK = {8'd99, 8'd98, 8'd97, 8'd96, 4'd5, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [37:0]   cfg_wdata = '0;
  logic [AW:0]   layer_cnt_i = '0;
  logic          start = 1'b0;
`ifdef LAYER_SEQ_LOOP_EN
  logic          loop_i = 1'b0;
`endif
  logic          busy, done, skip_err, ctrl_valid;
  logic          ctrl_ready = 1'b1;
  logic          ctrl_finish = 1'b0;
  logic [AW-1:0] cur_layer;
  logic [7:0]    w_num_o, h_num_o, c_num_o, co_num_o;
  logic [3:0]    shift_bias_o;
  logic          kernel_mode_o, is_diff_o, is_first_o;
  logic [37:0]   fields;

  assign fields = {w_num_o, h_num_o, c_num_o, co_num_o, shift_bias_o,
                   kernel_mode_o, is_diff_o};

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0, done_cnt = 0, skip_cnt = 0, valid_cnt = 0;

  layer_cfg_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .layer_cnt_i(layer_cnt_i), .start(start),
`ifdef LAYER_SEQ_LOOP_EN
    .loop_i(loop_i),
`endif
    .busy(busy), .done(done), .skip_err(skip_err), .cur_layer(cur_layer),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o), .co_num_o(co_num_o),
    .shift_bias_o(shift_bias_o), .kernel_mode_o(kernel_mode_o),
    .is_diff_o(is_diff_o), .is_first_o(is_first_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctrl_valid && ctrl_ready) xfer_cnt <= xfer_cnt + 1;
    if (done)       done_cnt  <= done_cnt + 1;
    if (skip_err)   skip_cnt  <= skip_cnt + 1;
    if (ctrl_valid) valid_cnt <= valid_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [37:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [AW:0] n);
    start = 1'b1; layer_cnt_i = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!ctrl_valid && k < 20) begin step(); k++; end
    chk("issue_seen", ctrl_valid, 1'b1);
  endtask

  // Expects ctrl_ready=1: checks the issued layer, then returns finish 5
  // cycles after the issue cycle.
  task automatic do_layer(input int idx, input logic [37:0] e, input logic first);
    wait_valid();
    if (!ctrl_valid) return;
    chk($sformatf("layer_idx_%0d", idx), cur_layer, idx[AW-1:0]);
    chk($sformatf("fields_%0d", idx), fields, e);
    chk($sformatf("is_first_%0d", idx), is_first_o, first);
    step();
    chk("valid_drop", ctrl_valid, 1'b0);
    start = 1'b1;            // must be ignored outside idle
    layer_cnt_i = 4'd0;
    repeat (4) step();
    start = 1'b0;
    ctrl_finish = 1'b1;
    step();
    ctrl_finish = 1'b0;
  endtask

  initial begin
    int x0, d0, s0, v0, bad, k;

    // Reset state
    step(); step();
    chk("rst_outs", {busy, done, skip_err, ctrl_valid, cur_layer, fields, is_first_o}, '0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 1'b0);

    write_entry(3'd0, E0);
    write_entry(3'd1, E1);
    write_entry(3'd2, E2);

    // Three valid layers back to back
    x0 = xfer_cnt; d0 = done_cnt;
    start_run(4'd3);
    chk("busy_after_start", busy, 1'b1);
    do_layer(0, E0, 1'b1);
    do_layer(1, E1, 1'b0);
    do_layer(2, E2, 1'b0);
    chk("done_pulse", done, 1'b1);
    step();
    chk("done_one_cycle", done, 1'b0);
    chk("busy_low_after", busy, 1'b0);
    chk("xfers_3", xfer_cnt - x0, 3);
    chk("dones_1", done_cnt - d0, 1);
    chk("fields_hold_idle", fields, E2);

    // Backpressure: ready low for 10 cycles in ISSUE, write attempt dropped
    ctrl_ready = 1'b0;
    x0 = xfer_cnt;
    start_run(4'd1);
    wait_valid();
    bad = 0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = JUNK;
    repeat (10) begin
      if (!ctrl_valid || fields !== E0 || cur_layer !== 3'd0) bad++;
      step();
      cfg_we = 1'b0;
    end
    chk("hold_stable", bad, 0);
    chk("hold_no_xfer", xfer_cnt - x0, 0);
    ctrl_ready = 1'b1;
    step();
    chk("hold_valid_drop", ctrl_valid, 1'b0);
    chk("hold_single_xfer", xfer_cnt - x0, 1);
    repeat (4) step();
    ctrl_finish = 1'b1;
    step();
    ctrl_finish = 1'b0;
    chk("hold_done", done, 1'b1);
    step();

    // Skip of a layer with c=0
    write_entry(3'd1, E1Z);
    x0 = xfer_cnt; s0 = skip_cnt; d0 = done_cnt;
    start_run(4'd3);
    do_layer(0, E0, 1'b1);       // also shows the busy-time write was dropped
    do_layer(2, E2, 1'b0);
    chk("skip_done", done, 1'b1);
    step();
    chk("skip_once", skip_cnt - s0, 1);
    chk("skip_xfers_2", xfer_cnt - x0, 2);

    // Zero and oversize counts end immediately with no issue
    v0 = valid_cnt;
    start_run(4'd0);
    chk("cnt0_done", done, 1'b1);
    step();
    chk("cnt0_idle", busy, 1'b0);
    start_run(4'd9);
    chk("cnt9_done", done, 1'b1);
    step();
    chk("bad_cnt_no_valid", valid_cnt - v0, 0);

    // Reset in RUN of layer 1
    write_entry(3'd1, E1);
    d0 = done_cnt;
    start_run(4'd3);
    do_layer(0, E0, 1'b1);
    wait_valid();
    chk("abort_layer1", cur_layer, 3'd1);
    step();                        // now in RUN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs", {busy, done, skip_err, ctrl_valid, cur_layer, fields, is_first_o}, '0);
    repeat (3) step();
    chk("abort_no_done", done_cnt - d0, 0);
    // Table was cleared: entry 0 is now all-zero and gets skipped
    start_run(4'd1);
    step();
    chk("cleared_skip", skip_err, 1'b1);
    chk("cleared_done", done, 1'b1);
    step();
    // Write and start in the same cycle: the run uses the new entry
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = E0;
    start_run(4'd1);
    cfg_we = 1'b0;
    do_layer(0, E0, 1'b1);
    chk("rerun_done", done, 1'b1);
    step();

`ifdef LAYER_SEQ_LOOP_EN
    write_entry(3'd1, E1);
    x0 = xfer_cnt; d0 = done_cnt;
    loop_i = 1'b1;
    start_run(4'd2);
    do_layer(0, E0, 1'b1);
    do_layer(1, E1, 1'b0);
    do_layer(0, E0, 1'b0);
    do_layer(1, E1, 1'b0);
    loop_i = 1'b0;
    do_layer(0, E0, 1'b0);
    do_layer(1, E1, 1'b0);
    chk("loop_done", done, 1'b1);
    step();
    chk("loop_xfers_6", xfer_cnt - x0, 6);
    chk("loop_dones_1", done_cnt - d0, 1);
`endif

    k = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
